// File: rtl/pattern_checker.sv
// pattern_checker: locks onto the 0x01 frame marker of the rotating pattern
// stream and checks each following word against the one-hot nibble rotation.
module pattern_checker #(
  parameter int unsigned LOSS_FRAMES = 2,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] frame_cnt
);

  typedef enum logic [1:0] {HUNT, SEED, LOCK} state_t;

  localparam logic [7:0] MARKER = 8'h01;
  localparam logic [3:0] LOSS   = 4'(LOSS_FRAMES);

  state_t     state;
  logic [2:0] pos;
  logic [7:0] prev;
  logic       frame_bad;
  logic [3:0] bad_streak;

  logic [7:0] expected;
  logic       mismatch;
  logic       is_data;
  logic       frame_bad_now;
  logic [3:0] streak_next;
  logic       err_inc;
  logic       frame_ok;

  // Expected word, format check and per-word event strobes
  always_comb begin
    expected      = 8'h00;
    mismatch      = 1'b0;
    is_data       = 1'b0;
    frame_bad_now = 1'b0;
    streak_next   = 4'd0;
    err_inc       = 1'b0;
    frame_ok      = 1'b0;
    // The chain passes through the marker: prev is held at pos 0.
    expected      = (pos == 3'd0) ? MARKER : {prev[6:4], prev[7], prev[3:0]};
    mismatch      = (in_data != expected);
    is_data       = (in_data[3:0] == 4'h0) &&
                    ((in_data[7:4] == 4'h1) || (in_data[7:4] == 4'h2) ||
                     (in_data[7:4] == 4'h4) || (in_data[7:4] == 4'h8));
    frame_bad_now = frame_bad | mismatch;
    streak_next   = bad_streak + 4'd1;
    err_inc       = in_valid && (state == LOCK) && mismatch;
    frame_ok      = in_valid && (state == LOCK) && (pos == 3'd7) && !frame_bad_now;
  end

  // Lock FSM with frame position tracking and registered lock/error outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= HUNT;
      pos        <= 3'd0;
      prev       <= 8'h00;
      frame_bad  <= 1'b0;
      bad_streak <= 4'd0;
      locked     <= 1'b0;
      err        <= 1'b0;
    end else begin
      err <= err_inc;
      if (in_valid) begin
        case (state)
          HUNT: begin
            if (in_data == MARKER) begin
              state <= SEED;
              pos   <= 3'd1;
            end
          end
          SEED: begin
            if (is_data) begin
              state      <= LOCK;
              locked     <= 1'b1;
              prev       <= in_data;
              pos        <= 3'd2;
              frame_bad  <= 1'b0;
              bad_streak <= 4'd0;
            end else if (in_data == MARKER) begin
              pos <= 3'd1;
            end else begin
              state <= HUNT;
              pos   <= 3'd0;
            end
          end
          LOCK: begin
            pos <= pos + 3'd1;
            // Track the expected value so a corrupted word cannot derail the chain.
            if (pos != 3'd0) prev <= expected;
            if (pos == 3'd7) begin
              frame_bad <= 1'b0;
              if (!frame_bad_now) begin
                bad_streak <= 4'd0;
              end else if (streak_next == LOSS) begin
                state      <= HUNT;
                locked     <= 1'b0;
                bad_streak <= 4'd0;
              end else begin
                bad_streak <= streak_next;
              end
            end else begin
              frame_bad <= frame_bad_now;
            end
          end
          default: begin
            state  <= HUNT;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

  // Saturating error and good-frame counters; clear wins over increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt   <= '0;
      frame_cnt <= '0;
    end else if (clr_cnt) begin
      err_cnt   <= '0;
      frame_cnt <= '0;
    end else begin
      if (err_inc && (err_cnt != {CNT_W{1'b1}}))
        err_cnt <= err_cnt + CNT_W'(1);
      if (frame_ok && (frame_cnt != {CNT_W{1'b1}}))
        frame_cnt <= frame_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pattern_checker.sv
// Directed bench for pattern_checker: a 4-bit-counter instance and a
// default-width instance share the same stimulus.
module tb_pattern_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        clr_cnt = 1'b0;

  logic        locked, err;
  logic [3:0]  err_cnt, frame_cnt;
  logic        locked16, err16;
  logic [15:0] err_cnt16, frame_cnt16;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pattern_checker #(.LOSS_FRAMES(2), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .clr_cnt(clr_cnt), .locked(locked), .err(err),
    .err_cnt(err_cnt), .frame_cnt(frame_cnt)
  );

  pattern_checker dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .clr_cnt(clr_cnt), .locked(locked16), .err(err16),
    .err_cnt(err_cnt16), .frame_cnt(frame_cnt16)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Generator stream word k: marker every 8 words, data nibble rotates through markers
  function automatic logic [7:0] gen(input int k);
    int d;
    logic [7:0] w;
    if (k % 8 == 0) return 8'h01;
    d = k - (k / 8) - 1;
    w = 8'h10 << (d % 4);
    return w;
  endfunction

  task automatic send(input logic [7:0] d, input logic v, input logic clr);
    @(negedge clk);
    in_valid = v;
    in_data  = d;
    clr_cnt  = clr;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    clr_cnt  = 1'b0;
  endtask

  task automatic word(input logic [7:0] d);
    send(d, 1'b1, 1'b0);
  endtask

  task automatic counts(input string tag, input int ec, input int fc4, input int fc16);
    check({tag, "_err_cnt"}, 16'(err_cnt), 16'(ec));
    check({tag, "_frame_cnt"}, 16'(frame_cnt), 16'(fc4));
    check({tag, "_err_cnt16"}, err_cnt16, 16'(ec));
    check({tag, "_frame_cnt16"}, frame_cnt16, 16'(fc16));
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_locked", 16'(locked), 16'd0);
    check("rst_err", 16'(err), 16'd0);
    counts("rst", 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;

    // Clean stream: lock after word 1, partial first frame counted at word 7
    word(gen(0));
    check("t1_locked_w0", 16'(locked), 16'd0);
    word(gen(1));
    check("t1_locked_w1", 16'(locked16), 16'd1);
    for (int k = 2; k < 40; k++) begin
      word(gen(k));
      check("t1_err", 16'(err), 16'd0);
      if (k == 6) counts("t1_w6", 0, 0, 0);
      if (k == 7) counts("t1_w7", 0, 1, 1);
    end
    check("t1_locked_end", 16'(locked), 16'd1);
    counts("t1_end", 0, 5, 5);

    // Single corrupted word: one err pulse, frame not counted, lock kept
    for (int k = 40; k < 56; k++) begin
      word((k == 43) ? 8'h60 : gen(k));
      if (k == 43) begin
        check("t2_err_pulse", 16'(err16), 16'd1);
        counts("t2_w43", 1, 5, 5);
      end
      if (k == 44) check("t2_err_after", 16'(err), 16'd0);
      if (k == 47) counts("t2_w47", 1, 5, 5);
    end
    check("t2_locked", 16'(locked), 16'd1);
    counts("t2_end", 1, 6, 6);

    // Clear on an idle cycle
    send(8'h00, 1'b0, 1'b1);
    counts("clr_idle", 0, 0, 0);

    // Two frames with bad markers: lock lost after second frame end, then relock
    for (int k = 56; k < 72; k++) begin
      word((k % 8 == 0) ? 8'h02 : gen(k));
      if (k == 56) check("t3_err_marker", 16'(err), 16'd1);
      if (k == 63) check("t3_locked_f1", 16'(locked), 16'd1);
      if (k == 70) check("t3_locked_w70", 16'(locked), 16'd1);
    end
    check("t3_unlocked", 16'(locked), 16'd0);
    check("t3_unlocked16", 16'(locked16), 16'd0);
    counts("t3_loss", 2, 0, 0);
    word(gen(72));
    check("t3_seed", 16'(locked), 16'd0);
    word(gen(73));
    check("t3_relock", 16'(locked), 16'd1);
    for (int k = 74; k < 80; k++) word(gen(k));
    counts("t3_end", 2, 1, 1);

    // in_valid toggling with garbage on idle cycles
    for (int k = 80; k < 96; k++) begin
      word(gen(k));
      send(8'h55, 1'b0, 1'b0);
      check("t4_idle_err", 16'(err), 16'd0);
    end
    check("t4_locked", 16'(locked), 16'd1);
    counts("t4_end", 2, 3, 3);

    // Saturation of the 4-bit frame counter
    for (int k = 96; k < 256; k++) begin
      word(gen(k));
      if (k == 191) counts("t5_w191", 2, 15, 15);
    end
    counts("t5_sat", 2, 15, 23);

    // Clear coinciding with a frame-end increment
    for (int k = 256; k < 263; k++) word(gen(k));
    send(gen(263), 1'b1, 1'b1);
    counts("t5_clr_wins", 0, 0, 0);
    for (int k = 264; k < 272; k++) word(gen(k));
    counts("t5_after_clr", 0, 1, 1);

    // Reset mid-frame at pos 4
    for (int k = 272; k < 276; k++) word(gen(k));
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = gen(276);
    rst = 1'b1;
    #1;
    check("t6_rst_locked", 16'(locked), 16'd0);
    check("t6_rst_err", 16'(err), 16'd0);
    counts("t6_rst", 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    word(8'h33);
    check("t6_garbage1", 16'(locked), 16'd0);
    word(8'h10);
    check("t6_garbage2", 16'(locked), 16'd0);
    counts("t6_hunt", 0, 0, 0);

    // Marker then non-data falls back to hunt; repeated marker stays seeded
    word(8'h01);
    word(8'h33);
    word(8'h20);
    check("t7_seed_reject", 16'(locked), 16'd0);
    word(8'h01);
    word(8'h01);
    check("t7_double_marker", 16'(locked), 16'd0);
    word(8'h80);
    check("t7_relock", 16'(locked), 16'd1);
    check("t7_relock16", 16'(locked16), 16'd1);
    word(8'h10);
    check("t7_chain_ok", 16'(err), 16'd0);
    word(8'h40);
    check("t7_chain_bad", 16'(err), 16'd1);
    counts("t7_end", 1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
